// File: rtl/shot_clock_pkg.sv
// Shared types and BCD helpers for the shot clock controller.
// Holds the state enum, the blank digit code and 2-digit BCD arithmetic.
package shot_clock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Binary 0..99 to packed two-digit BCD {tens, ones}.
    function automatic logic [7:0] to_bcd2(input int unsigned n);
        return {4'(n / 10), 4'(n % 10)};
    endfunction

    // Two-digit BCD decrement; 00 stays 00 so a stray call cannot wrap.
    function automatic logic [7:0] bcd_dec2(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h00)
            r = 8'h00;
        else if (v[3:0] == 4'd0)
            r = {v[7:4] - 4'd1, 4'd9};
        else
            r = {v[7:4], v[3:0] - 4'd1};
        return r;
    endfunction

    // Two-digit BCD increment that sticks at 99.
    function automatic logic [7:0] bcd_inc2_sat(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'h99)
            r = v;
        else if (v[3:0] == 4'd9)
            r = {v[7:4] + 4'd1, 4'd0};
        else
            r = {v[7:4], v[3:0] + 4'd1};
        return r;
    endfunction

endpackage

// File: rtl/pulse_div.sv
// Prescaler: counts 0..DIV-1 while en, pulse on the terminal count.
// Ports: clk, rst (sync, high), en (advance), clr (sync clear), pulse.
module pulse_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic pulse
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
    end

    // Gated by en so a count frozen at LAST (paused) never fires.
    assign pulse = en && (cnt == LAST);

endmodule

// File: rtl/shot_clock_ctrl.sv
// Shot clock controller: BCD countdown on d1/d0, score on d3/d2, scan strobe.
// Ports: clk, rst; start/pause/reload/score_inc pulses; scan_en, d3..d0, running, expired.
module shot_clock_ctrl
    import shot_clock_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int TICK_DIV  = 100000000,
    parameter int START_SEC = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       reload,
    input  logic       score_inc,
    output logic       scan_en,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic       running,
    output logic       expired
);

    localparam logic [7:0] START_BCD = to_bcd2(START_SEC);

    state_t     state, state_nx;
    logic [7:0] tm, tm_nx;
    logic [7:0] score, score_nx;
    logic       blink, blink_nx;
    logic       tick;
    logic       tick_en;
    logic       tick_clr;

    assign tick_en  = (state == RUN) || (state == EXPIRED);
    assign tick_clr = reload || ((state == IDLE) && start);

    pulse_div #(
        .DIV(SCAN_DIV)
    ) u_scan (
        .clk  (clk),
        .rst  (rst),
        .en   (1'b1),
        .clr  (1'b0),
        .pulse(scan_en)
    );

    pulse_div #(
        .DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en),
        .clr  (tick_clr),
        .pulse(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            tm    <= START_BCD;
            score <= 8'h00;
            blink <= 1'b0;
        end else begin
            state <= state_nx;
            tm    <= tm_nx;
            score <= score_nx;
            blink <= blink_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tm_nx    = tm;
        score_nx = score;
        blink_nx = blink;

        // Score is independent of reload; the expiring edge still counts.
        if (score_inc && ((state == RUN) || (state == PAUSE)))
            score_nx = bcd_inc2_sat(score);

        if (reload) begin
            state_nx = IDLE;
            tm_nx    = START_BCD;
            blink_nx = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !pause)
                        state_nx = RUN;
                end
                RUN: begin
                    // Decrement first; reaching 00 outranks a pause.
                    if (tick)
                        tm_nx = bcd_dec2(tm);
                    if (tick && (tm_nx == 8'h00))
                        state_nx = EXPIRED;
                    else if (pause)
                        state_nx = PAUSE;
                end
                PAUSE: begin
                    if (start && !pause)
                        state_nx = RUN;
                end
                EXPIRED: begin
                    if (tick)
                        blink_nx = ~blink;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign running = (state == RUN);
    assign expired = (state == EXPIRED);

    assign d3 = (score[7:4] == 4'd0) ? BCD_BLANK : score[7:4];
    assign d2 = score[3:0];
    assign d1 = (expired && blink) ? BCD_BLANK : tm[7:4];
    assign d0 = (expired && blink) ? BCD_BLANK : tm[3:0];

endmodule

// File: tb/tb_shot_clock_ctrl.sv
// Self-checking bench for shot_clock_ctrl (SCAN_DIV=4, TICK_DIV=8, START_SEC=10).
// Vector table, hand sequences for long corner cases, then random vs a model.
module tb_shot_clock_ctrl;

    localparam int SD = 4;
    localparam int TD = 8;
    localparam int SS = 10;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_EXP   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       reload = 1'b0;
    logic       score_inc = 1'b0;
    logic       scan_en;
    logic [3:0] d3, d2, d1, d0;
    logic       running, expired;

    int n_cmp = 0;
    int n_bad = 0;

    shot_clock_ctrl #(
        .SCAN_DIV (SD),
        .TICK_DIV (TD),
        .START_SEC(SS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .pause    (pause),
        .reload   (reload),
        .score_inc(score_inc),
        .scan_en  (scan_en),
        .d3       (d3),
        .d2       (d2),
        .d1       (d1),
        .d0       (d0),
        .running  (running),
        .expired  (expired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, pa, rl, si;
        logic       sc;
        logic [3:0] e3, e2, e1, e0;
        logic       er, ee;
    } vec_t;

    vec_t tbl[19];

    // Reference model state: plain integers, seconds and score in binary.
    int m_mode, m_time, m_score, m_ph, m_blink, m_cyc;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [17:0] disp_now();
        return {d3, d2, d1, d0, running, expired};
    endfunction

    function automatic logic [17:0] disp(input logic [3:0] a, b, c, d,
                                         input logic r, e);
        return {a, b, c, d, r, e};
    endfunction

    function automatic vec_t mk(input logic [3:0] in, input logic sc,
                                input logic [15:0] dd, input logic r, e);
        vec_t v;
        {v.st, v.pa, v.rl, v.si} = in;
        v.sc = sc;
        v.e3 = dd[15:12];
        v.e2 = dd[11:8];
        v.e1 = dd[7:4];
        v.e0 = dd[3:0];
        v.er = r;
        v.ee = e;
        return v;
    endfunction

    task automatic step(input logic st, pa, rl, si);
        start = st;
        pause = pa;
        reload = rl;
        score_inc = si;
        @(posedge clk);
        #1;
        start = 1'b0;
        pause = 1'b0;
        reload = 1'b0;
        score_inc = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        pause = 1'b0;
        reload = 1'b0;
        score_inc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic model_reset();
        m_mode = M_IDLE;
        m_time = SS;
        m_score = 0;
        m_ph = 0;
        m_blink = 0;
        m_cyc = 0;
    endtask

    task automatic model_step(input bit st, pa, rl, si);
        bit tick;
        tick = ((m_mode == M_RUN) || (m_mode == M_EXP)) && (m_ph == TD - 1);
        if (si && ((m_mode == M_RUN) || (m_mode == M_PAUSE)) && m_score < 99)
            m_score++;
        m_cyc++;
        if (rl) begin
            m_mode = M_IDLE;
            m_time = SS;
            m_ph = 0;
            m_blink = 0;
        end else begin
            case (m_mode)
                M_IDLE: if (st && !pa) begin
                    m_mode = M_RUN;
                    m_ph = 0;
                end
                M_RUN: begin
                    m_ph = (m_ph + 1) % TD;
                    if (tick)
                        m_time--;
                    if (m_time == 0)
                        m_mode = M_EXP;
                    else if (pa)
                        m_mode = M_PAUSE;
                end
                M_PAUSE: if (st && !pa)
                    m_mode = M_RUN;
                default: begin
                    m_ph = (m_ph + 1) % TD;
                    if (tick)
                        m_blink ^= 1;
                end
            endcase
        end
    endtask

    function automatic logic [18:0] model_out();
        logic [3:0] t, o, a, b;
        logic       bl;
        t  = 4'(m_score / 10);
        o  = 4'(m_score % 10);
        bl = (m_mode == M_EXP) && (m_blink == 1);
        a  = bl ? 4'hF : 4'(m_time / 10);
        b  = bl ? 4'hF : 4'(m_time % 10);
        return {(m_cyc % SD) == SD - 1, (t == 4'd0) ? 4'hF : t, o, a, b,
                m_mode == M_RUN, m_mode == M_EXP};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = mk(4'b0000, 1'b0, 16'hF010, 1'b0, 1'b0);
        tbl[1]  = mk(4'b0100, 1'b0, 16'hF010, 1'b0, 1'b0);
        tbl[2]  = mk(4'b0001, 1'b1, 16'hF010, 1'b0, 1'b0);
        tbl[3]  = mk(4'b1000, 1'b0, 16'hF010, 1'b1, 1'b0);
        tbl[4]  = mk(4'b0001, 1'b0, 16'hF110, 1'b1, 1'b0);
        tbl[5]  = mk(4'b0000, 1'b0, 16'hF110, 1'b1, 1'b0);
        tbl[6]  = mk(4'b0000, 1'b1, 16'hF110, 1'b1, 1'b0);
        tbl[7]  = mk(4'b0100, 1'b0, 16'hF110, 1'b0, 1'b0);
        tbl[8]  = mk(4'b0001, 1'b0, 16'hF210, 1'b0, 1'b0);
        tbl[9]  = mk(4'b1100, 1'b0, 16'hF210, 1'b0, 1'b0);
        tbl[10] = mk(4'b1000, 1'b1, 16'hF210, 1'b1, 1'b0);
        tbl[11] = mk(4'b0000, 1'b0, 16'hF210, 1'b1, 1'b0);
        tbl[12] = mk(4'b0000, 1'b0, 16'hF210, 1'b1, 1'b0);
        tbl[13] = mk(4'b0000, 1'b0, 16'hF210, 1'b1, 1'b0);
        tbl[14] = mk(4'b0000, 1'b1, 16'hF209, 1'b1, 1'b0);
        tbl[15] = mk(4'b0010, 1'b0, 16'hF210, 1'b0, 1'b0);
        tbl[16] = mk(4'b1010, 1'b0, 16'hF210, 1'b0, 1'b0);
        tbl[17] = mk(4'b0000, 1'b0, 16'hF210, 1'b0, 1'b0);
        tbl[18] = mk(4'b0000, 1'b1, 16'hF210, 1'b0, 1'b0);

        // Reset state and table-driven first 19 edges after release.
        do_reset();
        check("reset disp", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0)));
        check("reset scan", 32'(scan_en), 32'(1'b0));
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].st, tbl[i].pa, tbl[i].rl, tbl[i].si);
            check($sformatf("vec%0d scan", i), 32'(scan_en), 32'(tbl[i].sc));
            check($sformatf("vec%0d disp", i), 32'(disp_now()),
                  32'(disp(tbl[i].e3, tbl[i].e2, tbl[i].e1, tbl[i].e0,
                           tbl[i].er, tbl[i].ee)));
        end

        // Full countdown into EXPIRED and the blink phases.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 96; k++) begin
            int t;
            logic [17:0] e;
            step(k == 90, k == 91, 1'b0, k == 85);
            if (k <= 80) begin
                t = SS - k / TD;
                e = disp(4'hF, 4'h0, 4'(t / 10), 4'(t % 10), k < 80, k == 80);
            end else if (((k - 80) / TD) % 2 == 1) begin
                e = disp(4'hF, 4'h0, 4'hF, 4'hF, 1'b0, 1'b1);
            end else begin
                e = disp(4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1);
            end
            if (k % TD == 0 || k == 7 || k == 79)
                check($sformatf("countdown k=%0d", k), 32'(disp_now()), 32'(e));
        end

        // Pause with the second-phase counter at 4, hold, resume.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(11);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("pause entry", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h0, 4'h9, 1'b0, 1'b0)));
        idle(30);
        check("pause hold", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h0, 4'h9, 1'b0, 1'b0)));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(3);
        check("resume +3", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h0, 4'h9, 1'b1, 1'b0)));
        idle(1);
        check("resume +4", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h0, 4'h8, 1'b1, 1'b0)));

        // Score counting, blanking, saturation, survival across reload.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        check("score 05", 32'({d3, d2}), 32'(8'hF5));
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("score 06", 32'({d3, d2}), 32'(8'hF6));
        for (int i = 0; i < 6; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        check("score 12", 32'({d3, d2}), 32'(8'h12));
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        check("score sat", 32'({d3, d2}), 32'(8'h99));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("reload keeps score", 32'(disp_now()),
              32'(disp(4'h9, 4'h9, 4'h1, 4'h0, 1'b0, 1'b0)));

        // Reload at 05 in RUN, then a fresh full first second.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(37);
        check("run at 05", 32'(disp_now()),
              32'(disp(4'hF, 4'h3, 4'h0, 4'h5, 1'b1, 1'b0)));
        step(1'b0, 1'b0, 1'b1, 1'b0);
        check("reload to idle", 32'(disp_now()),
              32'(disp(4'hF, 4'h3, 4'h1, 4'h0, 1'b0, 1'b0)));
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle(7);
        check("restart +7", 32'(disp_now()),
              32'(disp(4'hF, 4'h3, 4'h1, 4'h0, 1'b1, 1'b0)));
        idle(1);
        check("restart +8", 32'(disp_now()),
              32'(disp(4'hF, 4'h3, 4'h0, 4'h9, 1'b1, 1'b0)));

        // Synchronous reset in the middle of a run clears the score.
        for (int i = 0; i < 4; i++)
            step(1'b0, 1'b0, 1'b0, 1'b1);
        idle(20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid-run rst disp", 32'(disp_now()),
              32'(disp(4'hF, 4'h0, 4'h1, 4'h0, 1'b0, 1'b0)));
        check("mid-run rst scan", 32'(scan_en), 32'(1'b0));
        rst = 1'b0;

        // Randomized traffic against the behavioural model.
        do_reset();
        model_reset();
        for (int n = 0; n < 4000; n++) begin
            bit st, pa, rl, si;
            if ($urandom_range(799) == 0) begin
                do_reset();
                model_reset();
            end else begin
                st = ($urandom_range(7) == 0);
                pa = ($urandom_range(15) == 0);
                rl = ($urandom_range(149) == 0);
                si = ($urandom_range(3) == 0);
                step(st, pa, rl, si);
                model_step(st, pa, rl, si);
            end
            check($sformatf("rand %0d", n), 32'({scan_en, disp_now()}),
                  32'(model_out()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
